// File: rtl/audio_dsm_multi_out.sv
// N-channel first-order delta-sigma 1-bit audio output with a frame FIFO.
// Frames are pushed via valid/ready, popped one per sample period, and modulated every clk.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   enable           1 = run sample divider and pop frames; 0 = hold regs forced to zero
//   in_data          frame, channel k at [k*WIDTH +: WIDTH], signed two's complement
//   in_valid         frame offered
//   in_ready         FIFO not full
//   fifo_level       frames stored (0..2**FIFO_LOG2)
//   sample_tick      one-cycle pulse at each sample-period boundary
//   underrun         one-cycle pulse: tick with FIFO empty
//   audio_out        1-bit modulator outputs, bit k = channel k
module audio_dsm_multi_out #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 16,
    parameter int DIV       = 408,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [FIFO_LOG2:0]        fifo_level,
    output logic                      sample_tick,
    output logic                      underrun,
    output logic [CHANNELS-1:0]       audio_out
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [FIFO_LOG2:0]   FULL    = (FIFO_LOG2+1)'(DEPTH);
    localparam logic [FIFO_LOG2:0]   LVL_ONE = (FIFO_LOG2+1)'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE = FIFO_LOG2'(1);
    localparam logic [CW-1:0]        CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);

    logic [CHANNELS*WIDTH-1:0] mem [DEPTH];
    logic [FIFO_LOG2-1:0]      wr_ptr;
    logic [FIFO_LOG2-1:0]      rd_ptr;
    logic [FIFO_LOG2:0]        level;

    logic [CW-1:0]             cnt;
    logic                      tick_q;

    logic [CHANNELS-1:0][WIDTH-1:0] hold;
    logic [CHANNELS-1:0][WIDTH-1:0] acc;
    logic [CHANNELS-1:0][WIDTH-1:0] u;
    logic [CHANNELS-1:0][WIDTH:0]   sum;

    logic push;
    logic pop;

    // Ready comes from registered level only, so a same-cycle pop never
    // opens a slot for a push when full.
    assign in_ready    = (level != FULL);
    assign fifo_level  = level;
    assign sample_tick = tick_q & enable;
    assign underrun    = sample_tick & (level == '0);
    assign push        = in_valid & in_ready;
    assign pop         = sample_tick & (level != '0);

    // Frame storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
        end
    end

    // Tick is registered: it is raised on the edge where the count wraps,
    // so the first tick lands DIV cycles after enable rises.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt    <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt    <= cnt + CNT_ONE;
            tick_q <= 1'b0;
        end
    end

    // Underrun keeps the last frame; disabling parks the output at mid-scale.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            hold <= '0;
        end else if (pop) begin
            hold <= mem[rd_ptr];
        end
    end

    // Sign flip turns two's complement into offset binary; the carry out
    // of the accumulator is the 1-bit output.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            u[k]   = {~hold[k][WIDTH-1], hold[k][WIDTH-2:0]};
            sum[k] = {1'b0, acc[k]} + {1'b0, u[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            audio_out <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc[k]       <= sum[k][WIDTH-1:0];
                audio_out[k] <= sum[k][WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_audio_dsm_multi_out.sv
// Scoreboard bench for audio_dsm_multi_out (2 channels, 8-bit, DIV=8, 4-deep FIFO).
// Accepted frames queue up as expected pops; a monitor checks every cycle.
module tb_audio_dsm_multi_out;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int FL = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fifo_level;
    logic          sample_tick;
    logic          underrun;
    logic [1:0]    audio_out;

    int n_chk;
    int n_fail;

    audio_dsm_multi_out #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .DIV      (D),
        .FIFO_LOG2(FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_level (fifo_level),
        .sample_tick(sample_tick),
        .underrun   (underrun),
        .audio_out  (audio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t: wait budget expired", nm, $time);
    endtask

    // Scoreboard state: frames the FIFO should hold, oldest first,
    // plus the expected hold contents and the enabled-cycle run length.
    logic [15:0] sb_q[$];
    logic [15:0] exp_hold;
    int          run_len;
    int          mon_sz;
    logic        exp_tick;

    initial begin
        exp_hold = '0;
        run_len  = 0;
    end

    always @(negedge clk) begin
        mon_sz   = sb_q.size();
        exp_tick = enable && run_len > 0 && (run_len % D) == 0;
        chk("hold", 32'(dut.hold), 32'(exp_hold));
        chk("fifo_level", 32'(fifo_level), 32'(mon_sz));
        chk("in_ready", 32'(in_ready), 32'(mon_sz != DEPTH));
        chk("sample_tick", 32'(sample_tick), 32'(exp_tick));
        chk("underrun", 32'(underrun), 32'(exp_tick && mon_sz == 0));
        if (reset) begin
            sb_q.delete();
            exp_hold = '0;
            run_len  = 0;
        end else begin
            if (!enable) begin
                exp_hold = '0;
            end else if (exp_tick && mon_sz > 0) begin
                exp_hold = sb_q.pop_front();
            end
            if (in_valid && mon_sz != DEPTH) begin
                sb_q.push_back(in_data);
            end
            run_len = enable ? run_len + 1 : 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_tick(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < budget);
        if (!sample_tick) timeout(nm);
    endtask

    // Ones per 2**W cycles equal the offset-binary code of a held sample.
    task automatic density(input string nm, input logic [15:0] frame);
        int c0;
        int c1;
        c0 = 0;
        c1 = 0;
        repeat (256) begin
            @(negedge clk);
            c0 += int'(audio_out[0]);
            c1 += int'(audio_out[1]);
        end
        chk({nm, "_ch0"}, 32'(c0), 32'(frame[7:0] ^ 8'h80));
        chk({nm, "_ch1"}, 32'(c1), 32'(frame[15:8] ^ 8'h80));
    endtask

    logic [15:0] frames [5];
    int          n_wait;

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_audio_out", 32'(audio_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        step();
        repeat (20) step();

        // Basic densities: mid-scale and full-scale positive
        push_frame(16'h7F00);
        enable = 1'b1;
        wait_tick("tick_first", 40);
        repeat (3) @(negedge clk);
        density("dens_7f00", 16'h7F00);
        step();
        push_frame(16'h8080);
        wait_tick("tick_8080", 40);
        repeat (3) @(negedge clk);
        density("dens_8080", 16'h8080);
        step();

        // Fill while disabled: fifth push refused, then in-order drain
        enable = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            frames[i] = 16'($urandom);
            in_valid  = 1'b1;
            in_data   = frames[i];
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        step();
        enable = 1'b1;
        repeat (D * 5 + 6) step();

        // Empty FIFO: underruns keep the last frame's density
        density("dens_underrun", frames[3]);
        wait_tick("tick_underrun", 40);
        chk("underrun_pulse", 32'(underrun), 32'd1);
        step();

        // Tick at full level with a push pending: push refused
        enable = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            push_frame(16'($urandom));
        end
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        enable   = 1'b1;
        wait_tick("tick_full", 40);
        chk("tick_full_level", 32'(fifo_level), 32'd4);
        chk("tick_full_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("after_tick_level", 32'(fifo_level), 32'd3);
        step();
        in_valid = 1'b0;

        // Reset mid-stream
        n_wait = 0;
        do begin
            @(negedge clk);
            n_wait++;
        end while (fifo_level != 3'd3 && n_wait < 100);
        if (fifo_level != 3'd3) timeout("wait_level3");
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_audio", 32'(audio_out), 32'd0);
        chk("mid_rst_hold", 32'(dut.hold), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        step();
        repeat (30) step();
        enable = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
